matmul_addr_seq: RTL and testbench
==================================

# matmul_addr_seq

Address sequencer for the matrix-multiply core. On `start` it walks the i/j/p loop nest of C = A·B and emits one (A, B) operand address pair per cycle to the MAC datapath. It steps A by 1 and B by the row stride N, which was previously a hard-wired constant. After each dot product it issues one C write strobe with its address. It sits between the host/config registers and the memory read ports plus MAC accumulator, and replaces the fixed-stride address register control.

## Interface
- AW, 16, address width; all address arithmetic is modulo 2^AW
- DW, 8, width of the dimension inputs M, N, K
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request; sampled only in IDLE
- cfg_m / cfg_n / cfg_k  in  DW each  rows of A / columns of B / inner dimension; latched on accepted start
- base_a / base_b / base_c  in  AW each  base addresses, row-major; latched on accepted start
- stall  in  1  memory/MAC back-pressure; freezes the sequencer
- addr_a / addr_b  out  AW each  operand addresses, qualified by mac_valid
- mac_valid  out  1  operand pair valid this cycle
- mac_first / mac_last  out  1 each  pair is p==0 / p==K-1 (accumulator clear / final)
- c_we  out  1  write accumulated result to addr_c
- addr_c  out  AW  result address
- busy  out  1  high in RUN and WRITE
- done  out  1  one-cycle pulse at job completion

## Operation
- Layout: A[i][p]=base_a+i·K+p; B[p][j]=base_b+p·N+j; C[i][j]=base_c+i·N+j.
- States: IDLE, RUN, WRITE, DONE.
- IDLE, start=1:
  - Latch config; i=j=p=0.
  - If any of M, N, K is 0 -> DONE. Otherwise -> RUN with addr_a=base_a, addr_b=base_b, addr_c=base_c.
- RUN:
  - mac_valid=1; mac_first=(p==0); mac_last=(p==K-1).
  - Advance only when stall=0.
  - Advance with p<K-1: p++, addr_a+=1, addr_b+=N.
  - Advance with p==K-1: -> WRITE.
- WRITE:
  - c_we=1, mac_valid=0. Advance only when stall=0.
  - On advance, addr_c+=1 and p=0.
  - If j<N-1: j++, addr_a=row_a (base_a+i·K), addr_b=base_b+j+1; -> RUN.
  - Else if i<M-1: i++, j=0, row_a+=K, addr_a=new row_a, addr_b=base_b; -> RUN.
  - Else -> DONE.
- DONE: done=1 for one cycle; -> IDLE.
- start is ignored outside IDLE, including in DONE.
- Handshake:
  - A pair or write is consumed in each cycle where (mac_valid or c_we) and stall=0.
  - Under stall, every output holds its value.
- Internal counters are DW bits. Products i·K and p·N are never formed; only incremental adds are used.
- Address overflow wraps silently.

## Timing
- Reset values: state IDLE; all outputs 0; latched config 0.
- Reset is asynchronous at any point, including mid-job. Aborting via reset produces no done and no further strobes.
- Start accepted at edge t: first mac_valid is in cycle t+1.
- With no stalls, RUN+WRITE occupy exactly M·N·(K+1) cycles. done is high in cycle t+1+M·N·(K+1).
- Zero dimension: done in cycle t+1; mac_valid and c_we stay 0.
- Each stall cycle adds exactly one cycle to the total.
- busy falls when done rises. A start in the done cycle is ignored; the earliest new accept is the cycle after done.

## Test plan
- M=N=K=2, base_a=0x000, base_b=0x100, base_c=0x200, no stall. Required:
  - (a,b) pairs: (000,100)(001,102) W200, (000,101)(001,103) W201, (002,100)(003,102) W202, (002,101)(003,103) W203.
  - done in cycle 13.
- K=1, M=1, N=3, bases 0/0x10/0x20. Required:
  - Every pair has mac_first=mac_last=1.
  - Pattern is pair, write, alternating.
  - addr_c sequence is 0x20, 0x21, 0x22; done in cycle 7.
- cfg_n=0 with start. Required: done in cycle 1; busy, mac_valid and c_we never asserted.
- 2x2x2 job with stall held for 3 cycles at p=1 of the first dot product, and for 2 cycles in the first WRITE. Required: outputs frozen during each stall; done in cycle 18; address sequence identical to the first test.
- Start pulsed mid-job with different config. Required: ignored, sequence unchanged. Then reset asserted mid-RUN: all outputs 0 immediately, and no done.
- base_b=0xFFFE, N=3, K=2. Required: addr_b steps 0xFFFE -> 0x0001 (wraps modulo 2^16).

Source files
------------

// File: rtl/matmul_addr_seq.sv
// matmul_addr_seq
// Address sequencer for the matrix-multiply core. Walks the i/j/p loop nest
// of C = A*B, emitting one (A, B) operand address pair per cycle and one
// C write strobe after each dot product. All address arithmetic is
// incremental (no multipliers); overflow wraps modulo 2^AW.
module matmul_addr_seq #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] cfg_m,
  input  logic [DW-1:0] cfg_n,
  input  logic [DW-1:0] cfg_k,
  input  logic [AW-1:0] base_a,
  input  logic [AW-1:0] base_b,
  input  logic [AW-1:0] base_c,
  input  logic          stall,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic          mac_valid,
  output logic          mac_first,
  output logic          mac_last,
  output logic          c_we,
  output logic [AW-1:0] addr_c,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;

  // Latched job configuration (held for the whole job, start is ignored
  // while a job is in flight).
  logic [DW-1:0] m_reg;
  logic [DW-1:0] n_reg;
  logic [DW-1:0] k_reg;
  logic [AW-1:0] base_b_reg;

  // Loop indices of the i/j/p nest.
  logic [DW-1:0] i_reg;
  logic [DW-1:0] j_reg;
  logic [DW-1:0] p_reg;

  // Incremental address trackers:
  //   row_a = base_a + i*K  (start of the current A row)
  //   col_b = base_b + j    (top of the current B column)
  logic [AW-1:0] row_a;
  logic [AW-1:0] col_b;

  // Loop-boundary flags and zero-extended strides.
  logic          last_p;
  logic          next_p_last;
  logic          last_j;
  logic          last_i;
  logic          zero_dim;
  logic          k_is_one;
  logic [AW-1:0] stride_n;
  logic [AW-1:0] stride_k;
  logic [AW-1:0] next_row_a;
  logic [AW-1:0] next_col_b;

  // Boundary detection and next-address arithmetic for the loop nest.
  always_comb begin
    last_p      = (p_reg == (k_reg - DW'(1)));
    next_p_last = ((p_reg + DW'(1)) == (k_reg - DW'(1)));
    last_j      = (j_reg == (n_reg - DW'(1)));
    last_i      = (i_reg == (m_reg - DW'(1)));
    zero_dim    = (cfg_m == '0) || (cfg_n == '0) || (cfg_k == '0);
    k_is_one    = (k_reg == DW'(1));
    stride_n    = AW'(n_reg);
    stride_k    = AW'(k_reg);
    next_row_a  = row_a + stride_k;
    next_col_b  = col_b + AW'(1);
  end

  // Sequencer FSM with registered outputs. Every output only changes on
  // an advancing edge, so a stalled cycle leaves them all untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      m_reg      <= '0;
      n_reg      <= '0;
      k_reg      <= '0;
      base_b_reg <= '0;
      i_reg      <= '0;
      j_reg      <= '0;
      p_reg      <= '0;
      row_a      <= '0;
      col_b      <= '0;
      addr_a     <= '0;
      addr_b     <= '0;
      addr_c     <= '0;
      mac_valid  <= 1'b0;
      mac_first  <= 1'b0;
      mac_last   <= 1'b0;
      c_we       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            m_reg      <= cfg_m;
            n_reg      <= cfg_n;
            k_reg      <= cfg_k;
            base_b_reg <= base_b;
            i_reg      <= '0;
            j_reg      <= '0;
            p_reg      <= '0;
            row_a      <= base_a;
            col_b      <= base_b;
            if (zero_dim) begin
              // Empty job: report completion without touching memory.
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= RUN;
              busy      <= 1'b1;
              mac_valid <= 1'b1;
              mac_first <= 1'b1;
              mac_last  <= (cfg_k == DW'(1));
              addr_a    <= base_a;
              addr_b    <= base_b;
              addr_c    <= base_c;
            end
          end
        end

        RUN: begin
          if (!stall) begin
            if (!last_p) begin
              // Next term of the dot product: walk A along the row and
              // B down the column.
              p_reg     <= p_reg + DW'(1);
              addr_a    <= addr_a + AW'(1);
              addr_b    <= addr_b + stride_n;
              mac_first <= 1'b0;
              mac_last  <= next_p_last;
            end else begin
              state     <= WRITE;
              mac_valid <= 1'b0;
              mac_first <= 1'b0;
              mac_last  <= 1'b0;
              c_we      <= 1'b1;
            end
          end
        end

        WRITE: begin
          if (!stall) begin
            c_we   <= 1'b0;
            addr_c <= addr_c + AW'(1);
            p_reg  <= '0;
            if (!last_j) begin
              // Next column of the same row: rewind A to the row start,
              // move B one column right.
              j_reg     <= j_reg + DW'(1);
              col_b     <= next_col_b;
              addr_a    <= row_a;
              addr_b    <= next_col_b;
              state     <= RUN;
              mac_valid <= 1'b1;
              mac_first <= 1'b1;
              mac_last  <= k_is_one;
            end else if (!last_i) begin
              // Next row: advance A by K, restart B at its first column.
              i_reg     <= i_reg + DW'(1);
              j_reg     <= '0;
              row_a     <= next_row_a;
              col_b     <= base_b_reg;
              addr_a    <= next_row_a;
              addr_b    <= base_b_reg;
              state     <= RUN;
              mac_valid <= 1'b1;
              mac_first <= 1'b1;
              mac_last  <= k_is_one;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        DONE: begin
          // start is deliberately not sampled here.
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_addr_seq.sv
// Testbench for matmul_addr_seq: directed jobs from the test plan plus
// randomized jobs with random back-pressure, all checked against a
// loop-nest reference model of the expected pair/write stream.
module tb_matmul_addr_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg_m = '0;
  logic [7:0]  cfg_n = '0;
  logic [7:0]  cfg_k = '0;
  logic [15:0] base_a = '0;
  logic [15:0] base_b = '0;
  logic [15:0] base_c = '0;
  logic        stall = 1'b0;
  logic [15:0] addr_a;
  logic [15:0] addr_b;
  logic        mac_valid;
  logic        mac_first;
  logic        mac_last;
  logic        c_we;
  logic [15:0] addr_c;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit          w;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    bit          f;
    bit          l;
  } ev_t;

  ev_t eq[$];
  int  stall_plan[$];

  matmul_addr_seq #(.AW(16), .DW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cfg_m     (cfg_m),
    .cfg_n     (cfg_n),
    .cfg_k     (cfg_k),
    .base_a    (base_a),
    .base_b    (base_b),
    .base_c    (base_c),
    .stall     (stall),
    .addr_a    (addr_a),
    .addr_b    (addr_b),
    .mac_valid (mac_valid),
    .mac_first (mac_first),
    .mac_last  (mac_last),
    .c_we      (c_we),
    .addr_c    (addr_c),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_addr_a"}, 32'(addr_a), 32'h0);
    check({tag, "_addr_b"}, 32'(addr_b), 32'h0);
    check({tag, "_addr_c"}, 32'(addr_c), 32'h0);
    check({tag, "_ctrl"}, 32'({mac_valid, mac_first, mac_last, c_we, busy, done}), 32'h0);
  endtask

  // Reference stream: plain loop nest over the row-major layout.
  task automatic build(input int m, input int n, input int k,
                       input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc);
    ev_t e;
    eq.delete();
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < n; j++) begin
        for (int p = 0; p < k; p++) begin
          e.w = 1'b0;
          e.a = ba + 16'(i * k + p);
          e.b = bb + 16'(p * n + j);
          e.c = bc + 16'(i * n + j);
          e.f = (p == 0);
          e.l = (p == k - 1);
          eq.push_back(e);
        end
        e.w = 1'b1;
        e.a = '0;
        e.b = '0;
        e.c = bc + 16'(i * n + j);
        e.f = 1'b0;
        e.l = 1'b0;
        eq.push_back(e);
      end
    end
  endtask

  task automatic run_job(input int m, input int n, input int k,
                         input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bc,
                         input int stall_pct, input int mid_start_at, input int reset_at);
    int  cyc;
    int  idx;
    int  rem;
    int  stalls;
    int  nev;
    ev_t e;
    build(m, n, k, ba, bb, bc);
    nev = eq.size();
    idx = 0;
    stalls = 0;
    rem = (stall_plan.size() > 0) ? stall_plan[0] : 0;
    $display("job m=%0d n=%0d k=%0d base_a=%h base_b=%h base_c=%h", m, n, k, ba, bb, bc);
    @(negedge clk);
    cfg_m = 8'(m); cfg_n = 8'(n); cfg_k = 8'(k);
    base_a = ba; base_b = bb; base_c = bc;
    start = 1'b1;
    stall = 1'b0;
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == mid_start_at) begin
        start = 1'b1;
        cfg_m = 8'd3; cfg_n = 8'd5; cfg_k = 8'd7;
        base_a = 16'h5555; base_b = 16'h6666; base_c = 16'h7777;
      end
      if (cyc > 2000) begin
        check("job_timeout", 32'(cyc), 32'(1 + nev + stalls));
        stall = 1'b0;
        eq.delete();
        return;
      end
      if (eq.size() > 0) begin
        e = eq[0];
        check("busy", 32'(busy), 32'h1);
        check("done_early", 32'(done), 32'h0);
        check("mac_valid", 32'(mac_valid), 32'(!e.w));
        check("c_we", 32'(c_we), 32'(e.w));
        if (!e.w) begin
          check("addr_a", 32'(addr_a), 32'(e.a));
          check("addr_b", 32'(addr_b), 32'(e.b));
          check("first_last", 32'({mac_first, mac_last}), 32'({e.f, e.l}));
        end else begin
          check("addr_c", 32'(addr_c), 32'(e.c));
        end
        if (cyc == reset_at) begin
          // Asynchronous abort: outputs clear before any clock edge.
          reset = 1'b1;
          stall = 1'b0;
          #1;
          check_all_zero("reset_abort");
          repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 32'({done, busy, mac_valid, c_we}), 32'h0);
          end
          reset = 1'b0;
          @(negedge clk);
          check("after_abort_idle", 32'({done, busy, mac_valid, c_we}), 32'h0);
          $display("job aborted by reset at cycle %0d", cyc);
          eq.delete();
          return;
        end
        if (rem > 0) begin
          stall = 1'b1;
          rem--;
          stalls++;
        end else if (stall_pct > 0 && $urandom_range(0, 99) < 32'(stall_pct)) begin
          stall = 1'b1;
          stalls++;
        end else begin
          stall = 1'b0;
          if (e.w) $display("  write c=%h", e.c);
          else     $display("  pair  a=%h b=%h first=%0d last=%0d", e.a, e.b, e.f, e.l);
          void'(eq.pop_front());
          idx++;
          rem = (idx < stall_plan.size()) ? stall_plan[idx] : 0;
        end
      end else begin
        stall = 1'b0;
        check("done", 32'(done), 32'h1);
        check("done_idle_outs", 32'({busy, mac_valid, c_we}), 32'h0);
        check("done_cycle", 32'(cyc), 32'(1 + nev + stalls));
        $display("job done at cycle %0d (stalls=%0d)", cyc, stalls);
        // A start in the done cycle must be ignored.
        start = 1'b1;
        cfg_m = 8'd1; cfg_n = 8'd1; cfg_k = 8'd1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_ignored", 32'({busy, mac_valid, c_we, done}), 32'h0);
        return;
      end
    end
  endtask

  initial begin
    int rm;
    int rn;
    int rk;

    // Reset state.
    @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");

    // 2x2x2 reference job.
    run_job(2, 2, 2, 16'h000, 16'h100, 16'h200, 0, -1, -1);

    // K=1: every pair is both first and last; pair/write alternate.
    run_job(1, 3, 1, 16'h000, 16'h010, 16'h020, 0, -1, -1);

    // Zero dimension: immediate done, no strobes.
    run_job(2, 0, 2, 16'h000, 16'h100, 16'h200, 0, -1, -1);

    // Directed stalls: 3 cycles at p=1 of the first dot product, 2 in the first write.
    stall_plan = '{0, 3, 2};
    run_job(2, 2, 2, 16'h000, 16'h100, 16'h200, 0, -1, -1);
    stall_plan.delete();

    // Start pulsed mid-job with a different config.
    run_job(2, 2, 2, 16'h000, 16'h100, 16'h200, 0, 3, -1);

    // Reset asserted mid-RUN.
    run_job(2, 3, 3, 16'h040, 16'h080, 16'h0c0, 0, -1, 2);

    // B address wraps modulo 2^16.
    run_job(2, 3, 2, 16'h000, 16'hfffe, 16'h300, 0, -1, -1);

    // Randomized jobs with random back-pressure.
    repeat (6) begin
      rm = int'($urandom_range(1, 4));
      rn = int'($urandom_range(1, 4));
      rk = int'($urandom_range(1, 4));
      run_job(rm, rn, rk, 16'($urandom), 16'($urandom), 16'($urandom), 30, -1, -1);
    end

    // Recovery after everything: one more clean job.
    run_job(3, 2, 3, 16'hfff0, 16'h1234, 16'hffff, 0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
